// File: rtl/siso_tx_ctrl.sv
// Serial-out transmit controller: loads a 4-bit word, shifts it LSB first on O with an SH strobe.
// Optional even-parity trailer bit when SISO_PARITY_EN is defined.
module siso_tx_ctrl #(
  parameter int GAP = 0
) (
  input  logic       C,
  input  logic       nCLR,
  input  logic [3:0] D,
  input  logic       LOAD,
  output logic       RDY,
  output logic       O,
  output logic       SH,
  output logic       BUSY,
  output logic       DONE
);

  localparam int DATA_W = 4;
`ifdef SISO_PARITY_EN
  localparam int         SHADOW_W = DATA_W + 1;
  localparam logic [2:0] LAST_CNT = 3'd4;
`else
  localparam int         SHADOW_W = DATA_W;
  localparam logic [2:0] LAST_CNT = 3'd3;
`endif
  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST} state_t;

  state_t              state, stateNxt;
  logic [2:0]          cnt, cntNxt;
  logic [2:0]          gapCnt, gapCntNxt;
  logic [SHADOW_W-1:0] shadow, shadowNxt, shadowShf;
  logic                oNxt, shNxt, doneNxt;

`ifdef SISO_PARITY_EN
  function automatic logic [SHADOW_W-1:0] packWord(input logic [DATA_W-1:0] w);
    return {^w, w};
  endfunction
`else
  function automatic logic [SHADOW_W-1:0] packWord(input logic [DATA_W-1:0] w);
    return w;
  endfunction
`endif

  assign RDY  = (state == IDLE) & nCLR;
  assign BUSY = (state != IDLE);

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    gapCntNxt = gapCnt;
    shadowNxt = shadow;
    shadowShf = shadow >> 1;
    oNxt      = 1'b0;
    shNxt     = 1'b0;
    doneNxt   = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD) begin
          shadowNxt = packWord(D);
          oNxt      = D[0];
          shNxt     = 1'b1;
          cntNxt    = 3'd0;
          stateNxt  = SHIFT;
        end
      end
      SHIFT: begin
        // Exit only after the last bit has been visible on O for a full cycle
        if (cnt == LAST_CNT) begin
          doneNxt   = 1'b1;
          gapCntNxt = 3'd0;
          stateNxt  = (GAP > 0) ? GAP_ST : IDLE;
        end else begin
          cntNxt    = cnt + 3'd1;
          oNxt      = shadowShf[0];
          shadowNxt = shadowShf;
          shNxt     = 1'b1;
        end
      end
      GAP_ST: begin
        if (gapCnt == GAP_LAST) stateNxt = IDLE;
        else gapCntNxt = gapCnt + 3'd1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(negedge C or negedge nCLR) begin
    if (!nCLR) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      gapCnt <= 3'd0;
      shadow <= '0;
      O      <= 1'b0;
      SH     <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= stateNxt;
      cnt    <= cntNxt;
      gapCnt <= gapCntNxt;
      shadow <= shadowNxt;
      O      <= oNxt;
      SH     <= shNxt;
      DONE   <= doneNxt;
    end
  end

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Directed bench for siso_tx_ctrl: one instance with GAP=0 and one with GAP=3 share all inputs.
module tb_siso_tx_ctrl;

`ifdef SISO_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       C = 1'b0;
  logic       nCLR;
  logic [3:0] D;
  logic       LOAD;
  logic       RDY0, O0, SH0, BUSY0, DONE0;
  logic       RDY3, O3, SH3, BUSY3, DONE3;
  logic       sel;
  logic       oS, shS, rdyS, busyS, doneS;
  logic [3:0] chain = 4'b0;
  int         total = 0;
  int         passed = 0;
  int         failed = 0;

  siso_tx_ctrl #(.GAP(0)) dut0 (
    .C(C), .nCLR(nCLR), .D(D), .LOAD(LOAD),
    .RDY(RDY0), .O(O0), .SH(SH0), .BUSY(BUSY0), .DONE(DONE0)
  );

  siso_tx_ctrl #(.GAP(3)) dut3 (
    .C(C), .nCLR(nCLR), .D(D), .LOAD(LOAD),
    .RDY(RDY3), .O(O3), .SH(SH3), .BUSY(BUSY3), .DONE(DONE3)
  );

  always #5 C = ~C;

  assign oS    = sel ? O3    : O0;
  assign shS   = sel ? SH3   : SH0;
  assign rdyS  = sel ? RDY3  : RDY0;
  assign busyS = sel ? BUSY3 : BUSY0;
  assign doneS = sel ? DONE3 : DONE0;

  // Downstream 4-stage chain fed by the GAP=0 instance; stage 0 is the output end
  always @(posedge C) if (SH0) chain <= {O0, chain[3:1]};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
  endtask

  task automatic rstPulse();
    LOAD = 1'b0;
    nCLR = 1'b0;
    tick();
    nCLR = 1'b1;
    #1;
    chk("rdy_after_rst", {3'b0, rdyS}, 4'h1);
  endtask

  task automatic runWord(input logic [3:0] w, input bit hold, input bit disturb);
    logic [4:0] bits;
    bits = {^w, w};
    D    = w;
    LOAD = 1'b1;
    tick();
    if (!hold) LOAD = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk("o_bit", {3'b0, oS}, {3'b0, bits[i]});
      chk("sh_shift", {3'b0, shS}, 4'h1);
      chk("busy_shift", {3'b0, busyS}, 4'h1);
      chk("rdy_shift", {3'b0, rdyS}, 4'h0);
      if (disturb && i == 1) begin
        LOAD = 1'b1;
        D    = 4'b0000;
      end
      if (disturb && i == 2) LOAD = 1'b0;
      tick();
    end
    chk("done_pulse", {3'b0, doneS}, 4'h1);
    chk("sh_end", {3'b0, shS}, 4'h0);
    chk("o_end", {3'b0, oS}, 4'h0);
  endtask

  initial begin
    sel  = 1'b0;
    nCLR = 1'b0;
    LOAD = 1'b0;
    D    = 4'b0;
    #2;
    chk("rst_rdy", {3'b0, RDY0}, 4'h0);
    chk("rst_o", {3'b0, O0}, 4'h0);
    chk("rst_sh", {3'b0, SH0}, 4'h0);
    chk("rst_busy", {3'b0, BUSY0}, 4'h0);
    chk("rst_done", {3'b0, DONE0}, 4'h0);
    tick();
    nCLR = 1'b1;
    #1;
    chk("rdy_release", {3'b0, RDY0}, 4'h1);

    // Single word, GAP=0
    runWord(4'b1011, 1'b0, 1'b0);
    chk("rdy_with_done", {3'b0, RDY0}, 4'h1);
    tick();
    chk("done_falls", {3'b0, DONE0}, 4'h0);
    chk("idle_busy", {3'b0, BUSY0}, 4'h0);

    // Back-to-back words with LOAD held, GAP=0, observed through the chain
    rstPulse();
    runWord(4'b0011, 1'b1, 1'b0);
    runWord(4'b1100, 1'b1, 1'b0);
    LOAD = 1'b0;
    #1;
`ifdef SISO_PARITY_EN
    chk("chain", chain, {1'b0, 3'b110});
`else
    chk("chain", chain, 4'b1100);
`endif

    // GAP=3 with LOAD held: idle window then second word
    rstPulse();
    sel = 1'b1;
    runWord(4'b0110, 1'b1, 1'b0);
    chk("gap_busy_done", {3'b0, BUSY3}, 4'h1);
    tick();
    chk("gap1_rdy", {3'b0, RDY3}, 4'h0);
    chk("gap1_busy", {3'b0, BUSY3}, 4'h1);
    chk("gap1_done", {3'b0, DONE3}, 4'h0);
    chk("gap1_sh", {3'b0, SH3}, 4'h0);
    tick();
    chk("gap2_rdy", {3'b0, RDY3}, 4'h0);
    chk("gap2_busy", {3'b0, BUSY3}, 4'h1);
    tick();
    chk("gap_end_rdy", {3'b0, RDY3}, 4'h1);
    chk("gap_end_busy", {3'b0, BUSY3}, 4'h0);
    runWord(4'b1001, 1'b0, 1'b0);
    sel = 1'b0;

    // Asynchronous abort mid-word
    rstPulse();
    D    = 4'b1111;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("abort_b0", {3'b0, O0}, 4'h1);
    tick();
    chk("abort_b1", {3'b0, O0}, 4'h1);
    chk("abort_sh_pre", {3'b0, SH0}, 4'h1);
    nCLR = 1'b0;
    #1;
    chk("abort_o", {3'b0, O0}, 4'h0);
    chk("abort_sh", {3'b0, SH0}, 4'h0);
    chk("abort_busy", {3'b0, BUSY0}, 4'h0);
    chk("abort_rdy", {3'b0, RDY0}, 4'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("abort_no_done", {3'b0, DONE0}, 4'h0);
      chk("abort_no_o", {3'b0, O0}, 4'h0);
    end
    nCLR = 1'b1;
    #1;
    chk("abort_rdy_rel", {3'b0, RDY0}, 4'h1);
    runWord(4'b0001, 1'b0, 1'b0);

    // LOAD and D disturbed during a word
    tick();
    runWord(4'b1010, 1'b0, 1'b1);
    tick();
    chk("ignored_busy", {3'b0, BUSY0}, 4'h0);
    chk("ignored_sh", {3'b0, SH0}, 4'h0);
    chk("ignored_rdy", {3'b0, RDY0}, 4'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
